// File: rtl/packet_transmitter.sv
// packet_transmitter: buffers payload bytes and emits SRC, DEST, SIZE, DATA..., CRC frames on the packet link
module packet_transmitter #(
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          wr_full,
   output logic [CW-1:0] fifo_count,
   input  logic          cmd_valid,
   input  logic [7:0]    cmd_src,
   input  logic [7:0]    cmd_dest,
   input  logic [7:0]    cmd_size,
   output logic          cmd_ready,
   input  logic          stop_packet_send,
   output logic          packet_valid_o,
   output logic [7:0]    pdata_o,
   output logic          busy,
   output logic          err_size
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] SRC  = 3'd1;
   localparam logic [2:0] DEST = 3'd2;
   localparam logic [2:0] SIZE = 3'd3;
   localparam logic [2:0] DATA = 3'd4;
   localparam logic [2:0] CRC  = 3'd5;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    state_q, state_d;
   logic [7:0]    dest_q, dest_d, size_q, size_d, cnt_q, cnt_d;
   logic [7:0]    crc_q, crc_d, pdata_q, pdata_d;
   logic          valid_q, valid_d, err_q, err_d;
   logic          push, pop, legal, accept, more;
   logic [7:0]    head;

   assign push       = wr_en && !wr_full;
   assign head       = mem_q[rd_ptr_q];
   assign legal      = cmd_size <= 8'(DEPTH);
   assign cmd_ready  = state_q == IDLE && !stop_packet_send && (!legal || 8'(count_q) >= cmd_size);
   assign accept     = cmd_valid && cmd_ready;
   assign wr_full    = count_q == CW'(DEPTH);
   assign fifo_count = count_q;
   assign busy       = state_q != IDLE;
   assign packet_valid_o = valid_q;
   assign pdata_o    = pdata_q;
   assign err_size   = err_q;
   assign wr_ptr_d   = wr_ptr_q + AW'(push);
   assign rd_ptr_d   = rd_ptr_q + AW'(pop);
   assign count_d    = count_q + CW'(push) - CW'(pop);
   // SIZE and DATA share the "next payload byte or CRC" decision
   assign more       = state_q == SIZE ? size_q != 8'd0 : cnt_q != 8'd0;

   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      pdata_d = pdata_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            err_d = accept && !legal;
            if (accept && legal) begin
               state_d = SRC;
               dest_d  = cmd_dest;
               size_d  = cmd_size;
               pdata_d = cmd_src;
               crc_d   = cmd_src;
               valid_d = 1'b1;
            end
         end
         SRC: begin
            state_d = DEST;
            pdata_d = dest_q;
            crc_d   = crc_q ^ dest_q;
         end
         DEST: begin
            state_d = SIZE;
            pdata_d = size_q;
            crc_d   = crc_q ^ size_q;
         end
         SIZE, DATA: begin
            state_d = more ? DATA : CRC;
            pdata_d = more ? head : crc_q;
            crc_d   = more ? crc_q ^ head : crc_q;
            cnt_d   = more ? (state_q == SIZE ? size_q : cnt_q) - 8'd1 : cnt_q;
            pop     = more;
         end
         default: begin
            state_d = IDLE;
            pdata_d = 8'd0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         dest_q   <= 8'd0;
         size_q   <= 8'd0;
         cnt_q    <= 8'd0;
         crc_q    <= 8'd0;
         pdata_q  <= 8'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         dest_q   <= dest_d;
         size_q   <= size_d;
         cnt_q    <= cnt_d;
         crc_q    <= crc_d;
         pdata_q  <= pdata_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_packet_transmitter.sv
// tb_packet_transmitter: directed vector table plus hand-written corner sequences
module tb_packet_transmitter;
   logic       clk1 = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_full;
   logic [4:0] fifo_count;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_src = 8'd0, cmd_dest = 8'd0, cmd_size = 8'd0;
   logic       cmd_ready;
   logic       stop_packet_send = 1'b0;
   logic       packet_valid_o;
   logic [7:0] pdata_o;
   logic       busy, err_size;
   int         n_chk = 0, n_fail = 0;

   typedef struct {
      logic       we;
      logic [7:0] wd;
      logic       cv;
      logic [7:0] cs, cd, cz;
      logic       ev;
      logic [7:0] ed;
      logic [4:0] ec;
   } vec_t;
   vec_t tv[$];

   packet_transmitter #(.DEPTH(16), .CW(5)) dut (
      .clk1(clk1), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .fifo_count(fifo_count), .cmd_valid(cmd_valid), .cmd_src(cmd_src), .cmd_dest(cmd_dest),
      .cmd_size(cmd_size), .cmd_ready(cmd_ready), .stop_packet_send(stop_packet_send),
      .packet_valid_o(packet_valid_o), .pdata_o(pdata_o), .busy(busy), .err_size(err_size)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic drive(input logic we, input logic [7:0] wd, input logic cv,
                        input logic [7:0] cs, input logic [7:0] cd, input logic [7:0] cz);
      wr_en = we; wr_data = wd; cmd_valid = cv; cmd_src = cs; cmd_dest = cd; cmd_size = cz;
   endtask

   task automatic out(input string nm, input logic ev, input logic [7:0] ed);
      chk({nm, " valid"}, int'(packet_valid_o), int'(ev));
      chk({nm, " pdata"}, int'(pdata_o), int'(ed));
   endtask

   task automatic push(input logic [7:0] d);
      drive(1'b1, d, cmd_valid, cmd_src, cmd_dest, cmd_size);
      step();
      wr_en = 1'b0;
   endtask

   function automatic vec_t v(input logic we, input logic [7:0] wd, input logic cv, input logic [7:0] cs,
                              input logic [7:0] cd, input logic [7:0] cz, input logic ev,
                              input logic [7:0] ed, input logic [4:0] ec);
      vec_t r;
      r.we = we; r.wd = wd; r.cv = cv; r.cs = cs; r.cd = cd; r.cz = cz; r.ev = ev; r.ed = ed; r.ec = ec;
      return r;
   endfunction

   initial begin
      // two-byte frame
      tv.push_back(v(1'b1, 8'd171, 1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd1));
      tv.push_back(v(1'b1, 8'd172, 1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd2));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd1, 8'd6,   8'd2, 1'b1, 8'd1,   5'd2));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd6,   5'd2));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd2,   5'd2));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd171, 5'd1));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd172, 5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd2,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd0));
      // four-byte frame with a queued zero-size command behind it
      tv.push_back(v(1'b1, 8'd111, 1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd1));
      tv.push_back(v(1'b1, 8'd122, 1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd2));
      tv.push_back(v(1'b1, 8'd133, 1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd3));
      tv.push_back(v(1'b1, 8'd144, 1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd4));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd1, 8'd150, 8'd4, 1'b1, 8'd1,   5'd4));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd150, 5'd4));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd4,   5'd4));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd111, 5'd3));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd122, 5'd2));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd133, 5'd1));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd144, 5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd147, 5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b0, 8'd0,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd9, 8'd8,   8'd0, 1'b1, 8'd9,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd8,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd0,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd1,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd0));
      // zero-size frame from an empty FIFO
      tv.push_back(v(1'b0, 8'd0,   1'b1, 8'd0, 8'd246, 8'd0, 1'b1, 8'd0,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd246, 5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd0,   5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b1, 8'd246, 5'd0));
      tv.push_back(v(1'b0, 8'd0,   1'b0, 8'd0, 8'd0,   8'd0, 1'b0, 8'd0,   5'd0));

      step();
      step();
      out("reset", 1'b0, 8'd0);
      chk("reset busy", int'(busy), 0);
      chk("reset err", int'(err_size), 0);
      chk("reset count", int'(fifo_count), 0);
      chk("reset full", int'(wr_full), 0);
      rst = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i].we, tv[i].wd, tv[i].cv, tv[i].cs, tv[i].cd, tv[i].cz);
         step();
         out($sformatf("vec%0d", i), tv[i].ev, tv[i].ed);
         chk($sformatf("vec%0d count", i), int'(fifo_count), int'(tv[i].ec));
         chk($sformatf("vec%0d busy", i), int'(busy), int'(tv[i].ev));
      end
      drive(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0);

      // back-pressure holds off the start, but not an active frame
      push(8'd10); push(8'd20); push(8'd30);
      stop_packet_send = 1'b1;
      drive(1'b0, 8'd0, 1'b1, 8'd5, 8'd7, 8'd3);
      #1 chk("stop ready", int'(cmd_ready), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         out("stop hold", 1'b0, 8'd0);
      end
      stop_packet_send = 1'b0;
      #1 chk("unstop ready", int'(cmd_ready), 1);
      step();
      out("unstop src", 1'b1, 8'd5);
      cmd_valid = 1'b0;
      stop_packet_send = 1'b1;
      step(); out("stop mid dest", 1'b1, 8'd7);
      step(); out("stop mid size", 1'b1, 8'd3);
      step(); out("stop mid d0", 1'b1, 8'd10);
      step(); out("stop mid d1", 1'b1, 8'd20);
      step(); out("stop mid d2", 1'b1, 8'd30);
      step(); out("stop mid crc", 1'b1, 8'd1);
      step(); out("stop mid end", 1'b0, 8'd0);
      stop_packet_send = 1'b0;

      // command waits for its full payload
      push(8'd40); push(8'd50);
      drive(1'b0, 8'd0, 1'b1, 8'd2, 8'd3, 8'd3);
      #1 chk("short ready", int'(cmd_ready), 0);
      step();
      out("short wait", 1'b0, 8'd0);
      push(8'd60);
      out("third push", 1'b0, 8'd0);
      chk("third ready", int'(cmd_ready), 1);
      step();
      out("wait src", 1'b1, 8'd2);
      cmd_valid = 1'b0;
      step(); out("wait dest", 1'b1, 8'd3);
      step(); out("wait size", 1'b1, 8'd3);
      step(); out("wait d0", 1'b1, 8'd40);
      step(); out("wait d1", 1'b1, 8'd50);
      step(); out("wait d2", 1'b1, 8'd60);
      step(); out("wait crc", 1'b1, 8'd36);
      step(); out("wait end", 1'b0, 8'd0);

      // oversize command
      push(8'd77);
      drive(1'b0, 8'd0, 1'b1, 8'd4, 8'd4, 8'd20);
      #1 chk("oversize ready", int'(cmd_ready), 1);
      step();
      cmd_valid = 1'b0;
      chk("oversize err", int'(err_size), 1);
      out("oversize nofrm", 1'b0, 8'd0);
      chk("oversize count", int'(fifo_count), 1);
      step();
      chk("oversize err pulse", int'(err_size), 0);
      chk("oversize busy", int'(busy), 0);

      // fill to full; the extra push must not disturb stored data
      for (int k = 0; k < 15; k++) push(8'(100 + k));
      chk("full flag", int'(wr_full), 1);
      chk("full count", int'(fifo_count), 16);
      push(8'd200);
      chk("overfill count", int'(fifo_count), 16);
      drive(1'b0, 8'd0, 1'b1, 8'd1, 8'd2, 8'd16);
      step();
      cmd_valid = 1'b0;
      step(); step(); step();
      out("full d0", 1'b1, 8'd77);
      step();
      out("full d1", 1'b1, 8'd100);
      chk("full d1 count", int'(fifo_count), 14);
      #2 rst = 1'b1;
      #1;
      out("async rst", 1'b0, 8'd0);
      chk("async rst count", int'(fifo_count), 0);
      chk("async rst busy", int'(busy), 0);
      chk("async rst full", int'(wr_full), 0);
      step();
      rst = 1'b0;
      step();
      out("post rst idle", 1'b0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
